// File: rtl/temporizador_fases.sv
// temporizador_fases: timing front end for the traffic-light controller.
// Divides clk into a slow tick, counts the duration of the phase selected
// by the fed-back light code (sel_luz) and emits a one-cycle step pulse
// that the downstream light FSM uses as its advance enable. Also
// conditions the raw service switch (2-flop synchronizer).
//
// Optional build macro: TF_DEBOUNCE_EN
//   defined   -> on_off additionally debounced over DEB_CYCLES clk cycles
//   undefined -> on_off is the plain synchronizer output (2-cycle latency)
module temporizador_fases #(
  parameter int PRESCALE   = 50000000,
  parameter int T_VERDE    = 10,
  parameter int T_AMARILLO = 3,
  parameter int T_ROJO     = 10,
  parameter int T_BLINK    = 1,
  parameter int CNT_W      = 8,
  parameter int DEB_CYCLES = 500000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             on_off_raw,
  input  logic [2:0]       sel_luz,
  output logic             on_off,
  output logic             tick,
  output logic             step,
  output logic [CNT_W-1:0] remaining
);

  localparam int PRE_W = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

  typedef enum logic [1:0] {
    CARGA  = 2'd0,
    CUENTA = 2'd1,
    PASO   = 2'd2
  } state_t;

  state_t           state;
  logic [PRE_W-1:0] presc;
  logic             sync_p0;
  logic             sync_p1;
  logic             on_off_q;
  logic [2:0]       sel_prev;
  logic             toggle;

  // Phase duration for a light code; out-of-service and unknown codes
  // blink, and a zero duration is promoted to one tick so the count
  // always terminates.
  function automatic logic [CNT_W-1:0] dur(input logic [2:0] code);
    logic [CNT_W-1:0] d;
    case (code)
      3'b100:  d = CNT_W'(T_VERDE);
      3'b010:  d = CNT_W'(T_AMARILLO);
      3'b001:  d = CNT_W'(T_ROJO);
      default: d = CNT_W'(T_BLINK);
    endcase
    if (d == '0) d = CNT_W'(1);
    return d;
  endfunction

  // Two-flop synchronizer for the asynchronous board switch.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= on_off_raw;
      sync_p1 <= sync_p0;
    end
  end

`ifdef TF_DEBOUNCE_EN
  localparam int DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES + 1) : 1;
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

  logic [DEB_W-1:0] deb_cnt;

  // Accept a new switch level only after it has differed from the current
  // level for DEB_CYCLES consecutive cycles; any reversion restarts the wait.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      deb_cnt <= '0;
      on_off  <= 1'b0;
    end else if (sync_p1 != on_off) begin
      if (deb_cnt == DEB_LAST) begin
        on_off  <= sync_p1;
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + DEB_W'(1);
      end
    end else begin
      deb_cnt <= '0;
    end
  end
`else
  assign on_off = sync_p1;
`endif

  // Any change of the conditioned switch since the last CUENTA cycle
  // forces a step; on_off_q only follows on_off while counting, so a
  // change seen during PASO or CARGA is held until CUENTA picks it up.
  assign toggle = on_off ^ on_off_q;

  // Strobe on the last prescaler count.
  assign tick = (presc == PRE_LAST);

  // Prescaler: free-running 0..PRESCALE-1, restarted whenever a phase
  // is loaded so every phase begins with a full tick period.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc <= '0;
    end else if (state == CARGA || tick) begin
      presc <= '0;
    end else begin
      presc <= presc + PRE_W'(1);
    end
  end

  // Phase sequencer: load duration, count ticks, then one PASO cycle with
  // step high. A light-code change not caused by step reloads the phase.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= CARGA;
      remaining <= '0;
      step      <= 1'b0;
      on_off_q  <= 1'b0;
      sel_prev  <= 3'b000;
    end else begin
      step <= 1'b0;
      case (state)
        CARGA: begin
          remaining <= dur(sel_luz);
          sel_prev  <= sel_luz;
          state     <= CUENTA;
        end
        CUENTA: begin
          on_off_q <= on_off;
          if (toggle) begin
            state <= PASO;
            step  <= 1'b1;
          end else if (sel_luz != sel_prev) begin
            state <= CARGA;
          end else if (tick) begin
            if (remaining == CNT_W'(1)) begin
              state <= PASO;
              step  <= 1'b1;
            end else begin
              remaining <= remaining - CNT_W'(1);
            end
          end
        end
        PASO: begin
          state <= CARGA;
        end
        default: begin
          state <= CARGA;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_temporizador_fases.sv
// Self-checking bench for temporizador_fases with PRESCALE=4, T_VERDE=3,
// T_AMARILLO=2, T_ROJO=3, T_BLINK=1, DEB_CYCLES=8.
module tb_temporizador_fases;

  logic       clk = 1'b0;
  logic       reset;
  logic       on_off_raw;
  logic [2:0] sel_luz;
  logic       on_off;
  logic       tick;
  logic       step;
  logic [7:0] remaining;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [2:0] sel;
    logic       raw;
    int         rem;
    int         interval;
  } vec_t;

  vec_t vecs[8];

  temporizador_fases #(
    .PRESCALE(4), .T_VERDE(3), .T_AMARILLO(2), .T_ROJO(3),
    .T_BLINK(1), .CNT_W(8), .DEB_CYCLES(8)
  ) dut (
    .clk(clk), .reset(reset), .on_off_raw(on_off_raw), .sel_luz(sel_luz),
    .on_off(on_off), .tick(tick), .step(step), .remaining(remaining)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Counts cycles until step is seen high, bounded by max.
  task automatic wait_step(input int max, output int n);
    n = 0;
    do begin
      cyc();
      n++;
    end while (step !== 1'b1 && n < max);
    if (step !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL wait_step timeout got=%0d exp=step", n);
    end
  endtask

  // Called in a PASO cycle: present the next phase and measure it.
  task automatic run_row(input int i);
    int n;
    sel_luz    = vecs[i].sel;
    on_off_raw = vecs[i].raw;
    cyc();
    check($sformatf("row%0d step_width", i), step, 0);
    cyc();
    check($sformatf("row%0d rem_load", i), remaining, vecs[i].rem);
    check($sformatf("row%0d step_cuenta", i), step, 0);
    repeat (3) cyc();
    check($sformatf("row%0d first_tick", i), tick, 1);
    check($sformatf("row%0d rem_at_tick", i), remaining, vecs[i].rem);
    wait_step(60, n);
    check($sformatf("row%0d interval", i), 5 + n, vecs[i].interval);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    vecs[0] = '{3'b100, 1'b1, 3, 14};
    vecs[1] = '{3'b010, 1'b1, 2, 10};
    vecs[2] = '{3'b001, 1'b1, 3, 14};
    vecs[3] = '{3'b000, 1'b0, 1, 6};
    vecs[4] = '{3'b111, 1'b0, 1, 6};
    vecs[5] = '{3'b000, 1'b0, 1, 6};
    vecs[6] = '{3'b011, 1'b0, 1, 6};
    vecs[7] = '{3'b111, 1'b0, 1, 6};

    reset      = 1'b0;
    on_off_raw = 1'b1;
    sel_luz    = 3'b100;
    repeat (3) cyc();

`ifdef TF_DEBOUNCE_EN
    begin
      logic dropped;
      sel_luz = 3'b000;
      check("deb_reset_on_off", on_off, 0);
      reset = 1'b1;
      repeat (9) cyc();
      check("deb_rise_c9", on_off, 0);
      cyc();
      check("deb_rise_c10", on_off, 1);
      repeat (5) cyc();
      on_off_raw = 1'b0;
      repeat (5) cyc();
      on_off_raw = 1'b1;
      dropped = 1'b0;
      for (int i = 0; i < 20; i++) begin
        cyc();
        if (on_off !== 1'b1) dropped = 1'b1;
      end
      check("deb_glitch_kept", dropped, 0);
      on_off_raw = 1'b0;
      repeat (9) cyc();
      check("deb_fall_c9", on_off, 1);
      cyc();
      check("deb_fall_c10", on_off, 0);
      on_off_raw = 1'b1;
      repeat (9) cyc();
      check("deb_rerise_c9", on_off, 0);
      cyc();
      check("deb_rerise_c10", on_off, 1);
    end
`else
    // Reset state, then power-on: on_off rising forces the first step.
    check("rst_on_off", on_off, 0);
    check("rst_tick", tick, 0);
    check("rst_step", step, 0);
    check("rst_remaining", remaining, 0);
    reset = 1'b1;
    cyc();
    check("init_rem_load", remaining, 3);
    check("init_on_off_c1", on_off, 0);
    cyc();
    check("init_on_off_c2", on_off, 1);
    wait_step(10, n);
    check("init_toggle_step", n, 1);

    // Green -> yellow -> red.
    for (int i = 0; i < 3; i++) run_row(i);

    // Switch off mid-green with a non-terminal tick in the toggle cycle.
    sel_luz = 3'b100;
    repeat (2) cyc();
    check("A_rem_load", remaining, 3);
    repeat (4) cyc();
    check("A_rem_2", remaining, 2);
    cyc();
    on_off_raw = 1'b0;
    cyc();
    check("A_on_off_c1", on_off, 1);
    cyc();
    check("A_on_off_c2", on_off, 0);
    check("A_step_c2", step, 0);
    check("A_tick_c2", tick, 1);
    cyc();
    check("A_step", step, 1);
    check("A_rem_no_dec", remaining, 2);

    // Out of service: blink patterns, one step per tick.
    for (int i = 3; i < 8; i++) run_row(i);

    // Toggle and terminal tick in the same cycle give one step.
    sel_luz = 3'b000;
    repeat (3) cyc();
    on_off_raw = 1'b1;
    cyc();
    check("B_on_off_c1", on_off, 0);
    cyc();
    check("B_on_off_c2", on_off, 1);
    check("B_tick", tick, 1);
    check("B_rem", remaining, 1);
    cyc();
    check("B_step", step, 1);
    sel_luz = 3'b100;
    wait_step(40, n);
    check("B_single_step", n, 14);

    // Switch change landing in a CARGA caused by a light-code change.
    repeat (2) cyc();
    check("C_rem_load", remaining, 3);
    cyc();
    on_off_raw = 1'b0;
    cyc();
    sel_luz = 3'b010;
    cyc();
    check("C_carga_step", step, 0);
    check("C_carga_rem", remaining, 3);
    check("C_carga_on_off", on_off, 0);
    cyc();
    check("C_reload_rem", remaining, 2);
    check("C_reload_step", step, 0);
    cyc();
    check("C_held_toggle_step", step, 1);

    // Asynchronous reset mid-phase as a tick is firing.
    on_off_raw = 1'b1;
    repeat (2) cyc();
    check("D_on_off", on_off, 1);
    cyc();
    check("D_toggle_step", step, 1);
    repeat (5) cyc();
    check("D_pre_tick", tick, 1);
    check("D_pre_rem", remaining, 2);
    check("D_pre_step", step, 0);
    reset = 1'b0;
    #1;
    check("D_rst_step", step, 0);
    check("D_rst_tick", tick, 0);
    check("D_rst_rem", remaining, 0);
    check("D_rst_on_off", on_off, 0);
    on_off_raw = 1'b0;
    repeat (2) cyc();
    check("D_hold_rem", remaining, 0);
    reset = 1'b1;
    cyc();
    check("D_rel_rem", remaining, 2);
    check("D_rel_step", step, 0);
    wait_step(20, n);
    check("D_full_phase", n, 8);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/temporizador_fases.md
Name: temporizador_fases

Overview:
- Timing front end for the traffic-light controller. Sits directly upstream of the light-sequencing FSM.
- Divides the board clock into a slow tick and counts a per-phase duration selected by the FSM's current light code (sel_luz, fed back).
- Emits a one-cycle step pulse that the FSM uses as its state-advance enable.
- Also conditions the raw on_off switch (2-flop synchronizer) before it reaches the FSM.

Parameters:
- PRESCALE, 50000000, clk cycles per tick (1 s at 50 MHz); minimum 2.
- T_VERDE, 10, green duration in ticks.
- T_AMARILLO, 3, yellow duration in ticks.
- T_ROJO, 10, red duration in ticks.
- T_BLINK, 1, duration of each out-of-service pattern (000/111) in ticks.
- CNT_W, 8, width of the phase counter; all T_* values must be below 2^CNT_W.
- DEB_CYCLES, 500000, debounce stability window in clk cycles (optional feature only).

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  reset, asynchronous, active-low.
- on_off_raw  in  1  raw service switch from the board.
- sel_luz  in  3  current light code fed back from the downstream FSM.
- on_off  out  1  conditioned switch level to the FSM.
- tick  out  1  one-cycle prescaler strobe.
- step  out  1  one-cycle advance pulse to the FSM.
- remaining  out  CNT_W  ticks left in the current phase.

Behaviour:
- Reset (reset=0, asynchronous): state=CARGA; prescaler=0; remaining=0; step=0; tick=0; on_off=0; both synchronizer flops=0.
- on_off path: on_off_raw passes through 2 flops, so on_off follows it with 2-cycle latency. on_off_q holds the previous conditioned value; toggle = on_off ^ on_off_q.
- Prescaler: counts 0..PRESCALE-1. tick=1 for exactly one cycle when the count is PRESCALE-1, then wraps to 0. The count is forced to 0 in CARGA.
- Duration decode dur(sel_luz):
  - 100 -> T_VERDE; 010 -> T_AMARILLO; 001 -> T_ROJO.
  - 000, 111 and every other code -> T_BLINK.
  - A decoded value of 0 is treated as 1.
- sel_prev register: loaded with sel_luz in CARGA.
- FSM states and transitions:
  - CARGA: remaining <= dur(sel_luz); sel_prev <= sel_luz; go to CUENTA.
  - CUENTA, evaluated in this priority order:
    1. toggle=1 -> PASO.
    2. sel_luz != sel_prev -> CARGA. This covers an external FSM reset or a phase change not caused by step.
    3. tick=1 and remaining==1 -> PASO.
    4. tick=1 otherwise -> remaining <= remaining-1.
    5. Otherwise hold.
  - PASO: step=1 (Moore output, registered state, glitch-free); go to CARGA unconditionally.
- Step timing:
  - step is high exactly one cycle.
  - Minimum spacing between steps is 3 cycles (PASO -> CARGA -> CUENTA -> PASO).
  - The FSM advances on the clock edge that ends PASO, so CARGA loads the new phase's duration.
- Latency: after the tick that finds remaining==1, step is high in the following cycle.
- Simultaneous events: a toggle and a terminal tick in the same cycle produce one step, not two. A toggle arriving during PASO or CARGA is not lost; on_off_q only updates in CUENTA.
- Reset mid-phase: outputs return to reset values immediately. After release, the first phase duration is decoded from whatever sel_luz shows.

Optional Feature:
- Macro TF_DEBOUNCE_EN.
- Defined: after the synchronizer, on_off changes only once the synchronized input has differed from on_off for DEB_CYCLES consecutive cycles. A debounce counter of ceil(log2(DEB_CYCLES+1)) bits resets to 0 on any reversion. Latency is 2+DEB_CYCLES cycles.
- Undefined: debounce logic absent; latency is 2 cycles.

Test Plan (PRESCALE=4, T_VERDE=3, T_AMARILLO=2, T_ROJO=3, T_BLINK=1, DEB_CYCLES=8):
- Release reset, on_off_raw=1, sel_luz=100 -> remaining loads 3 one cycle after release. tick every 4 cycles. remaining steps 3->2->1. step=1 for one cycle right after the third tick.
- Bench FSM model advances sel_luz 100->010->001->100 on each step -> step intervals follow 3,2,3 ticks (+2-cycle overhead each). remaining reloads 2, then 3.
- on_off_raw 1->0 mid-green (remaining=2) -> on_off falls 2 cycles later. step=1 in the next cycle. prescaler is 0 in the following CARGA.
- on_off=0, bench alternates sel_luz 000/111 on each step -> one step per tick (+overhead). remaining always loads 1.
- reset pulled low while remaining=2 and tick would fire -> step, tick, remaining and on_off all 0 immediately. No step seen after release until a full phase has elapsed.
- With TF_DEBOUNCE_EN: a 5-cycle low glitch on on_off_raw leaves on_off=1. A 10-cycle low produces on_off=0 exactly 10 cycles after the edge.
